// File: rtl/l2_noc3_msg_deserializer.sv
// l2_noc3_msg_deserializer
// Assembles NoC3 flits (one header plus up to MAX_PAYLOAD data flits) into whole
// messages and queues them in a DEPTH-entry FIFO in front of L2 pipe2 S1.
// Handshakes: a transfer happens on a clock edge where valid && ready are both high.
// valid never waits on ready, and ready never depends combinationally on valid.
// state_dbg exposes the assembly FSM (0 = HDR, 1 = PAYLOAD).
module l2_noc3_msg_deserializer #(
  parameter int MAX_PAYLOAD = 2,
  parameter int DEPTH       = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      noc3_valid_in,
  input  logic [63:0]               noc3_data_in,
  output logic                      noc3_ready_in,
  output logic                      msg_valid,
  input  logic                      msg_ready,
  output logic [63:0]               msg_header,
  output logic [64*MAX_PAYLOAD-1:0] msg_data,
  output logic                      msg_trunc,
  output logic                      overflow_err,
  output logic                      state_dbg
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [7:0]    MAXP  = 8'(MAX_PAYLOAD);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);

  typedef enum logic {ST_HDR = 1'b0, ST_PAYLOAD = 1'b1} state_t;

  state_t                    state, state_next;
  logic [63:0]               asm_hdr;
  logic [64*MAX_PAYLOAD-1:0] asm_data, data_merged;
  logic [7:0]                idx, remaining;
  logic                      accept, pop;
  logic                      push, push_trunc;
  logic [63:0]               push_hdr;
  logic [64*MAX_PAYLOAD-1:0] push_data;
  logic [7:0]                flit_len, asm_len;

  logic [63:0]               hdr_mem   [DEPTH];
  logic [64*MAX_PAYLOAD-1:0] data_mem  [DEPTH];
  logic                      trunc_mem [DEPTH];
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             count;

  assign flit_len      = noc3_data_in[29:22];
  assign asm_len       = asm_hdr[29:22];
  assign noc3_ready_in = (count != FULL);
  assign msg_valid     = (count != '0);
  assign accept        = noc3_valid_in && noc3_ready_in;
  assign pop           = msg_valid && msg_ready;
  assign state_dbg     = state;

  // FIFO head is decoded straight from storage registers
  assign msg_header = hdr_mem[rd_ptr];
  assign msg_data   = data_mem[rd_ptr];
  assign msg_trunc  = trunc_mem[rd_ptr];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HDR;
    else        state <= state_next;
  end

  // FSM next-state: leave HDR on a non-empty header, return after the last payload flit
  always_comb begin
    state_next = state;
    case (state)
      ST_HDR:     if (accept && flit_len != 8'd0) state_next = ST_PAYLOAD;
      ST_PAYLOAD: if (accept && remaining == 8'd1) state_next = ST_HDR;
      default:    state_next = ST_HDR;
    endcase
  end

  // FSM outputs: merge the incoming payload flit and decide when a message is pushed
  always_comb begin
    data_merged = asm_data;
    for (int i = 0; i < MAX_PAYLOAD; i++) begin
      if (idx == 8'(i)) data_merged[64*i +: 64] = noc3_data_in;
    end
    push       = 1'b0;
    push_hdr   = asm_hdr;
    push_data  = data_merged;
    push_trunc = 1'b0;
    case (state)
      ST_HDR: begin
        if (accept && flit_len == 8'd0) begin
          push      = 1'b1;
          push_hdr  = noc3_data_in;
          push_data = '0;
        end
      end
      ST_PAYLOAD: begin
        if (accept && remaining == 8'd1) begin
          push       = 1'b1;
          push_trunc = (asm_len > MAXP);
        end
      end
      default: ;
    endcase
  end

  // Assembly registers: header latch, payload collection, saturating index, sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_hdr      <= '0;
      asm_data     <= '0;
      idx          <= '0;
      remaining    <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (accept) begin
        if (state == ST_HDR) begin
          asm_hdr   <= noc3_data_in;
          asm_data  <= '0;
          remaining <= flit_len;
          idx       <= '0;
        end else begin
          asm_data  <= data_merged;
          remaining <= remaining - 8'd1;
          if (idx < MAXP) idx <= idx + 8'd1;
        end
      end
      if (push && push_trunc) overflow_err <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage; no reset needed because msg_valid gates the head
  always_ff @(posedge clk) begin
    if (push) begin
      hdr_mem[wr_ptr]   <= push_hdr;
      data_mem[wr_ptr]  <= push_data;
      trunc_mem[wr_ptr] <= push_trunc;
    end
  end

endmodule

// File: tb/tb_l2_noc3_msg_deserializer.sv
// Bench for l2_noc3_msg_deserializer: directed scenarios plus randomized traffic,
// checked every cycle against a message-level reference model.
module tb_l2_noc3_msg_deserializer;

  localparam int MAXP  = 2;
  localparam int DEPTH = 2;
  localparam int W     = 1 + 64 * MAXP + 64;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 noc3_valid_in = 1'b0;
  logic [63:0]          noc3_data_in = '0;
  logic                 noc3_ready_in;
  logic                 msg_valid;
  logic                 msg_ready = 1'b0;
  logic [63:0]          msg_header;
  logic [64*MAXP-1:0]   msg_data;
  logic                 msg_trunc;
  logic                 overflow_err;
  logic                 state_dbg;

  int errors = 0;
  int checks = 0;
  int sent   = 0;
  int m_pops = 0;
  bit run_cmp = 1'b0;

  // reference model state: queue of completed messages {trunc, data, header}
  logic [W-1:0]  exp_q[$];
  logic [63:0]   pay_q[$];
  logic [63:0]   cur_hdr;
  int            need;
  bit            in_msg = 1'b0;
  bit            m_ovf  = 1'b0;

  l2_noc3_msg_deserializer #(.MAX_PAYLOAD(MAXP), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .noc3_valid_in(noc3_valid_in), .noc3_data_in(noc3_data_in),
    .noc3_ready_in(noc3_ready_in),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_header(msg_header), .msg_data(msg_data), .msg_trunc(msg_trunc),
    .overflow_err(overflow_err), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: a message is complete once len payload flits have followed its header
  task automatic model_push();
    logic [64*MAXP-1:0] d;
    logic               tr;
    d = '0;
    for (int i = 0; i < MAXP; i++) if (i < pay_q.size()) d[64*i +: 64] = pay_q[i];
    tr = (need > MAXP);
    if (tr) m_ovf = 1'b1;
    exp_q.push_back({tr, d, cur_hdr});
  endtask

  task automatic model_flit(input logic [63:0] d);
    if (!in_msg) begin
      cur_hdr = d;
      need    = int'(d[29:22]);
      pay_q.delete();
      if (need == 0) model_push();
      else in_msg = 1'b1;
    end else begin
      pay_q.push_back(d);
      if (pay_q.size() == need) begin
        model_push();
        in_msg = 1'b0;
      end
    end
  endtask

  // model update at each edge; acceptance uses the model's own occupancy
  always @(posedge clk or negedge rst_n) begin
    bit can_take;
    if (!rst_n) begin
      exp_q.delete();
      pay_q.delete();
      in_msg = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      can_take = (exp_q.size() != DEPTH);
      if (exp_q.size() != 0 && msg_ready) begin
        void'(exp_q.pop_front());
        m_pops++;
      end
      if (noc3_valid_in && can_take) model_flit(noc3_data_in);
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (rst_n && run_cmp) begin
      chk("ready", {255'd0, noc3_ready_in}, {255'd0, exp_q.size() != DEPTH});
      chk("valid", {255'd0, msg_valid}, {255'd0, exp_q.size() != 0});
      chk("overflow", {255'd0, overflow_err}, {255'd0, m_ovf});
      if (msg_valid && exp_q.size() != 0)
        chk("head", {63'd0, msg_trunc, msg_data, msg_header}, {63'd0, exp_q[0]});
    end
  end

  // driver: present one flit and hold it until accepted (tasks start/end after a negedge)
  task automatic send_flit(input logic [63:0] d);
    int  guard;
    bit  r;
    guard = 0;
    noc3_valid_in = 1'b1;
    noc3_data_in  = d;
    forever begin
      r = noc3_ready_in;
      @(negedge clk);
      if (r) break;
      guard++;
      if (guard > 500) begin
        chk("send_timeout", 256'd1, 256'd0);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    noc3_valid_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_msg(input logic [63:0] hdr);
    send_flit(hdr);
    for (int i = 0; i < int'(hdr[29:22]); i++) send_flit({$urandom, $urandom});
    sent++;
  endtask

  int  low_cnt;
  bit  rand_done;

  initial begin
    // reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmp = 1'b1;
    chk("rst_valid", {255'd0, msg_valid}, 256'd0);
    chk("rst_ready", {255'd0, noc3_ready_in}, 256'd1);
    chk("rst_ovf", {255'd0, overflow_err}, 256'd0);
    chk("rst_state", {255'd0, state_dbg}, 256'd0);

    // len=0 header, type 0x12
    msg_ready = 1'b1;
    send_flit(64'h0000_0000_0004_8000);
    sent++;
    noc3_valid_in = 1'b0;
    chk("t1_valid", {255'd0, msg_valid}, 256'd1);
    chk("t1_hdr", {192'd0, msg_header}, 256'h48000);
    chk("t1_data", {128'd0, msg_data}, 256'd0);
    chk("t1_trunc", {255'd0, msg_trunc}, 256'd0);
    idle(2);

    // len=2, A then B; popped in the third cycle after the header
    send_flit(64'h0000_0000_0080_0000);
    send_flit(64'hAAAA_AAAA_AAAA_AAAA);
    send_flit(64'hBBBB_BBBB_BBBB_BBBB);
    sent++;
    noc3_valid_in = 1'b0;
    chk("t2_valid", {255'd0, msg_valid}, 256'd1);
    chk("t2_data", {128'd0, msg_data}, {128'd0, 128'hBBBB_BBBB_BBBB_BBBB_AAAA_AAAA_AAAA_AAAA});
    @(negedge clk);
    chk("t2_popped", {255'd0, msg_valid}, 256'd0);
    idle(1);

    // len=3: third payload dropped, truncation flagged
    send_flit(64'h0000_0000_00C0_0000);
    send_flit(64'h1111_0000_0000_0000);
    send_flit(64'h2222_0000_0000_0001);
    send_flit(64'h3333_0000_0000_0002);
    sent++;
    noc3_valid_in = 1'b0;
    chk("t3_data", {128'd0, msg_data}, {128'd0, 128'h2222_0000_0000_0001_1111_0000_0000_0000});
    chk("t3_trunc", {255'd0, msg_trunc}, 256'd1);
    chk("t3_ovf", {255'd0, overflow_err}, 256'd1);
    idle(3);

    // back-pressure: two len=1 messages fill the FIFO, the third header stalls
    msg_ready = 1'b0;
    @(negedge clk);
    send_msg(64'h0000_0000_0040_0040);
    send_msg(64'h0000_0000_0040_0080);
    noc3_valid_in = 1'b0;
    chk("t4_ready_low", {255'd0, noc3_ready_in}, 256'd0);
    fork
      send_msg(64'h0000_0000_0040_00C0);
      begin
        repeat (4) @(negedge clk);
        chk("t4_still_low", {255'd0, noc3_ready_in}, 256'd0);
        chk("t4_head", {192'd0, msg_header}, 256'h40_0040);
        msg_ready = 1'b1;
      end
    join
    idle(6);
    chk("t4_drained", {255'd0, msg_valid}, 256'd0);

    // streaming len=1 messages: ready never drops
    low_cnt = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) send_msg({$urandom, 32'h0040_0000 | ($urandom & 32'hFF03_FFFF)} & 64'hFFFF_FFFF_C07F_FFFF | 64'h40_0000);
      end
      begin
        repeat (20) begin
          @(negedge clk);
          if (!noc3_ready_in) low_cnt++;
        end
      end
    join
    chk("t5_ready_drops", low_cnt, 0);
    idle(3);
    chk("t3_ovf_sticky", {255'd0, overflow_err}, 256'd1);

    // randomized traffic with random back-pressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [63:0] h;
          h = {$urandom, $urandom};
          h[29:22] = 8'($urandom_range(0, 4));
          send_msg(h);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        noc3_valid_in = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          msg_ready = ($urandom_range(0, 2) != 0);
          @(negedge clk);
        end
      end
    join
    msg_ready = 1'b1;
    idle(6);
    chk("rand_drained", {255'd0, msg_valid}, 256'd0);

    // reset during a partially assembled message
    send_flit(64'h0000_0000_0080_0000);
    send_flit(64'h5555_5555_5555_5555);
    noc3_valid_in = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_valid", {255'd0, msg_valid}, 256'd0);
    chk("t6_ready", {255'd0, noc3_ready_in}, 256'd1);
    chk("t6_ovf", {255'd0, overflow_err}, 256'd0);
    chk("t6_state", {255'd0, state_dbg}, 256'd0);
    send_flit(64'h0000_0000_0004_8040);
    sent++;
    noc3_valid_in = 1'b0;
    chk("t6_new_valid", {255'd0, msg_valid}, 256'd1);
    chk("t6_new_hdr", {192'd0, msg_header}, 256'h4_8040);
    chk("t6_new_data", {128'd0, msg_data}, 256'd0);
    idle(4);
    chk("msg_count", m_pops, sent);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
